// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - parametrised pipelined ripple-carry adder with valid/ready handshake
// Each stage adds one SEG-bit slice and forwards the partial sum plus the operands still to be added.
module pipelined_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  localparam int SEG = WIDTH / STAGES;

  generate
    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_rca: WIDTH must be a positive multiple of STAGES");
    end
  endgenerate

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];

  logic [STAGES:0]   ready;
  logic [STAGES-1:0] valid_in;
  logic [STAGES-1:0] carry_in;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  sum_in [STAGES];
  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic [WIDTH-1:0]  sum_d  [STAGES];
  logic [SEG:0]      seg_sum;

  // Stage k can take data if out_ready is high or any stage at or after k is empty.
  always_comb begin
    ready[STAGES] = out_ready;
    for (int k = 0; k < STAGES; k++) begin
      ready[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_in[0] = in_valid;
    carry_in[0] = cin;
    sum_in[0]   = '0;
    a_in[0]     = a;
    b_in[0]     = b;
    for (int k = 1; k < STAGES; k++) begin
      valid_in[k] = valid_q[k-1];
      carry_in[k] = carry_q[k-1];
      sum_in[k]   = sum_q[k-1];
      a_in[k]     = a_q[k-1];
      b_in[k]     = b_q[k-1];
    end
    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_sum = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, carry_in[k]};
      sum_d[k]               = sum_in[k];
      sum_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      carry_d[k]             = seg_sum[SEG];
      load[k]                = valid_in[k] && ready[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          carry_q[k] <= carry_d[k];
          sum_q[k]   <= sum_d[k];
          a_q[k]     <= a_in[k];
          b_q[k]     <= b_in[k];
        end else if (ready[k+1]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign carry     = carry_q[STAGES-1];
  assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                     (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_rca.sv
// tb/tb_pipelined_rca.sv - self-checking bench for pipelined_rca (W16/S4, W4/S1, W4/S2)
module tb_pipelined_rca;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv, ir, ov, ordy, cin, carry, ovf;
  logic [15:0] a, b, sum;
  logic        iv4, cin4, ir1, ir2, ov1, ov2, c1, c2, f1, f2;
  logic [3:0]  a4, b4, s1, s2;

  pipelined_rca #(.WIDTH(16), .STAGES(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(cin),
    .out_valid(ov), .out_ready(ordy), .sum(sum), .carry(carry), .ovf(ovf));
  pipelined_rca #(.WIDTH(4), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir1), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov1), .out_ready(1'b1), .sum(s1), .carry(c1), .ovf(f1));
  pipelined_rca #(.WIDTH(4), .STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir2), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov2), .out_ready(1'b1), .sum(s2), .carry(c2), .ovf(f2));

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int n_out = 0;
  int tot1 = 0;
  int tot2 = 0;
  logic [17:0] q16[$];
  logic [5:0]  q1[$];
  logic [5:0]  q2[$];
  logic [5:0]  e1, e2;
  logic [17:0] e16;
  logic [15:0] corner [5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition, ovf from operand/result signs.
  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] f;
    f = {1'b0, x} + {1'b0, y} + 17'(c);
    return {(x[15] == y[15]) && (f[15] != x[15]), f};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] f;
    f = {1'b0, x} + {1'b0, y} + 5'(c);
    return {(x[3] == y[3]) && (f[3] != x[3]), f};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov) begin
        if (q16.size() == 0) chk("unexpected_out_w16", ov, 0);
        else begin
          chk("out_w16", {ovf, carry, sum}, q16[0]);
          if (ordy) begin
            e16 = q16.pop_front();
            n_out++;
          end
        end
      end
      if (iv && ir) begin
        q16.push_back(model16(a, b, cin));
        n_acc++;
      end
      if (ov1) begin
        if (q1.size() == 0) chk("unexpected_out_w4s1", ov1, 0);
        else begin
          e1 = q1.pop_front();
          chk("out_w4s1", {f1, c1, s1}, e1);
          tot1++;
        end
      end
      if (ov2) begin
        if (q2.size() == 0) chk("unexpected_out_w4s2", ov2, 0);
        else begin
          e2 = q2.pop_front();
          chk("out_w4s2", {f2, c2, s2}, e2);
          tot2++;
        end
      end
      if (iv4 && ir1) q1.push_back(model4(a4, b4, cin4));
      if (iv4 && ir2) q2.push_back(model4(a4, b4, cin4));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic one_shot(input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic [17:0] exp, input string name);
    int  n;
    bit  seen;
    tick();
    a = x; b = y; cin = c; iv = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, ir, 1);
    tick();
    iv = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (ov) seen = 1;
    end
    chk({name, "_latency"}, n, 4);
    chk({name, "_result"}, {ovf, carry, sum}, exp);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q16.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, q16.size(), 0);
    chk({name, "_count"}, n_out, n_acc);
  endtask

  initial begin
    int gaps, stalls, acc0;
    logic [17:0] exp_r;
    rst_n = 1'b0; iv = 0; ordy = 1; a = 0; b = 0; cin = 0;
    iv4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    tick();
    chk("rst_out_valid", ov, 0);
    chk("rst_sum", {ovf, carry, sum}, 0);
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid_w4", {ov1, ov2}, 0);
    repeat (2) tick();
    rst_n = 1'b1;

    one_shot(16'hFFFF, 16'h0001, 1'b0, 18'h10000, "t1_ffff_1");
    one_shot(16'hFFFF, 16'h0000, 1'b1, 18'h10000, "t2_carry_chain");
    one_shot(16'h7FFF, 16'h0001, 1'b0, 18'h28000, "t2_pos_ovf");
    one_shot(16'h8000, 16'h8000, 1'b0, 18'h30000, "t2_neg_ovf");

    tick();
    gaps = 0; stalls = 0; ordy = 1;
    for (int i = 0; i < 2000; i++) begin
      iv  = 1'b1;
      a   = (i % 7 == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      b   = (i % 5 == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      if (i >= 4 && !ov) gaps++;
      if (!ir) stalls++;
      tick();
    end
    iv = 0;
    chk("stream_gaps", gaps, 0);
    chk("stream_stalls", stalls, 0);
    drain("stream");

    acc0 = n_acc; ordy = 0; iv = 1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      tick();
    end
    chk("bp_accepted", n_acc - acc0, 4);
    @(negedge clk);
    chk("bp_in_ready", ir, 0);
    chk("bp_out_valid", ov, 1);
    tick();
    for (int i = 0; i < 300; i++) begin
      ordy = 1'($urandom); iv = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      tick();
    end
    iv = 0; ordy = 1;
    drain("bp");

    ordy = 0; iv = 1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      tick();
    end
    iv = 0;
    tick();
    chk("rst_pre_out_valid", ov, 1);
    #2 rst_n = 1'b0;
    q16.delete(); n_acc = 0; n_out = 0;
    #1;
    chk("midrst_out_valid", ov, 0);
    chk("midrst_outputs", {ovf, carry, sum}, 0);
    chk("midrst_in_ready", ir, 1);
    ordy = 1;
    repeat (2) tick();
    chk("midrst_in_ready_held", ir, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", ov, 0);
    end
    a = 16'($urandom); b = 16'($urandom);
    exp_r = model16(a, b, 1'b1);
    one_shot(a, b, 1'b1, exp_r, "post_rst");
    drain("post_rst");

    for (int i = 0; i < 512; i++) begin
      {cin4, a4, b4} = 9'(i);
      iv4 = 1'b1;
      tick();
    end
    iv4 = 0;
    repeat (5) tick();
    chk("w4s1_total", tot1, 512);
    chk("w4s2_total", tot2, 512);
    chk("w4_queues_empty", q1.size() + q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
